// File: rtl/kanagawa_hal_sync_showahead_fifo.sv
// Single-clock show-ahead FIFO: RAM + read stage + prefetch register,
// with used-word count, thresholds, flush and optional sticky error flags.
module kanagawa_hal_sync_showahead_fifo #(
   parameter int DEPTH                      = 32,
   parameter int LOG_DEPTH                  = $clog2(DEPTH),
   parameter int WIDTH                      = 32,
   parameter int USEDW_WIDTH                = LOG_DEPTH + 1,
   parameter int ALMOSTFULL_ENTRIES         = 4,
   parameter int ALMOSTEMPTY_ENTRIES        = 1,
   parameter int USE_LUTRAM                 = 0,
   parameter int OVER_UNDER_FLOW_PROTECTION = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wrreq,
   input  logic [WIDTH-1:0]       data,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   rdreq,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [WIDTH-1:0]       q,
   output logic [USEDW_WIDTH-1:0] usedw,
   output logic                   overflow,
   output logic                   underflow
);

   localparam logic [USEDW_WIDTH-1:0] L_FULL = USEDW_WIDTH'(DEPTH);
   localparam logic [USEDW_WIDTH-1:0] L_AF   =
      USEDW_WIDTH'(DEPTH - ALMOSTFULL_ENTRIES);
   localparam logic [USEDW_WIDTH-1:0] L_AE   =
      USEDW_WIDTH'(ALMOSTEMPTY_ENTRIES);
   localparam logic [LOG_DEPTH-1:0]   L_LAST = LOG_DEPTH'(DEPTH - 1);

   if (DEPTH < 4) begin : g_bad_depth
      $error("DEPTH must be at least 4");
   end
   if (LOG_DEPTH != $clog2(DEPTH)) begin : g_bad_log
      $error("LOG_DEPTH inconsistent with DEPTH");
   end
   if (DEPTH - ALMOSTFULL_ENTRIES < 1) begin : g_bad_af
      $error("DEPTH - ALMOSTFULL_ENTRIES must be at least 1");
   end

   logic [LOG_DEPTH-1:0]   r_wr_ptr;
   logic [LOG_DEPTH-1:0]   r_rd_ptr;
   logic [USEDW_WIDTH-1:0] r_ram_cnt;
   logic [USEDW_WIDTH-1:0] r_usedw;
   logic                   r_s1_valid;
   logic                   r_q_valid;
   logic [WIDTH-1:0]       r_s1;
   logic [WIDTH-1:0]       r_q;
   logic                   r_full;
   logic                   r_af;
   logic                   r_ae;
   logic                   r_ovf;
   logic                   r_udf;

   logic                   w_wr_req;
   logic                   w_rd_req;
   logic                   w_wr;
   logic                   w_pop;
   logic                   w_q_load;
   logic                   w_issue;
   logic [USEDW_WIDTH-1:0] w_usedw_nxt;

   function automatic logic [LOG_DEPTH-1:0] f_inc(
      input logic [LOG_DEPTH-1:0] p
   );
      return (p == L_LAST) ? '0 : p + LOG_DEPTH'(1);
   endfunction

   // Unknown request levels count as idle.
   assign w_wr_req = (wrreq === 1'b1);
   assign w_rd_req = (rdreq === 1'b1);

   assign w_wr     = w_wr_req && !r_full && !flush;
   assign w_pop    = w_rd_req && r_q_valid && !flush;
   assign w_q_load = (!r_q_valid || w_pop) && r_s1_valid;
   assign w_issue  = (r_ram_cnt != '0) && (!r_s1_valid || w_q_load);

   assign w_usedw_nxt = r_usedw + USEDW_WIDTH'(w_wr)
                      - USEDW_WIDTH'(w_pop);

   if (USE_LUTRAM != 0) begin : g_lutram
      (* ram_style = "distributed" *)
      logic [WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
         if (w_wr) r_mem[r_wr_ptr] <= data;
         if (w_issue) r_s1 <= r_mem[r_rd_ptr];
      end
   end else begin : g_bram
      (* ram_style = "block" *)
      logic [WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
         if (w_wr) r_mem[r_wr_ptr] <= data;
         if (w_issue) r_s1 <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (w_q_load) r_q <= r_s1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ram_cnt  <= '0;
         r_usedw    <= '0;
         r_s1_valid <= 1'b0;
         r_q_valid  <= 1'b0;
         r_full     <= 1'b0;
         r_af       <= 1'b1;
         r_ae       <= 1'b1;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ram_cnt  <= '0;
         r_usedw    <= '0;
         r_s1_valid <= 1'b0;
         r_q_valid  <= 1'b0;
         r_full     <= 1'b0;
         r_af       <= 1'b0;
         r_ae       <= 1'b1;
      end else begin
         if (w_wr) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_issue) r_rd_ptr <= f_inc(r_rd_ptr);
         r_ram_cnt <= r_ram_cnt + USEDW_WIDTH'(w_wr)
                    - USEDW_WIDTH'(w_issue);
         if (w_issue) r_s1_valid <= 1'b1;
         else if (w_q_load) r_s1_valid <= 1'b0;
         if (w_q_load) r_q_valid <= 1'b1;
         else if (w_pop) r_q_valid <= 1'b0;
         r_usedw <= w_usedw_nxt;
         r_full  <= (w_usedw_nxt == L_FULL);
         r_af    <= (w_usedw_nxt >= L_AF);
         r_ae    <= (w_usedw_nxt <= L_AE);
         if (OVER_UNDER_FLOW_PROTECTION != 0) begin
            if (w_wr_req && r_full) r_ovf <= 1'b1;
            if (w_rd_req && !r_q_valid) r_udf <= 1'b1;
         end
      end
   end

   // Unprotected mode: report illegal requests once reset has been seen.
   if (OVER_UNDER_FLOW_PROTECTION == 0) begin : g_chk
      logic r_seen_rst;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_seen_rst <= 1'b1;
         else r_seen_rst <= r_seen_rst;
      end
      always @(posedge clk) begin
         if (r_seen_rst && !rst && !flush) begin
            assert (!(w_wr_req && r_full))
               else $error("%m overflow");
            assert (!(w_rd_req && !r_q_valid))
               else $error("%m underflow");
         end
      end
   end

   assign full         = r_full;
   assign almost_full  = r_af;
   assign empty        = !r_q_valid;
   assign almost_empty = r_ae;
   assign q            = r_q;
   assign usedw        = r_usedw;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_kanagawa_hal_sync_showahead_fifo.sv
// Directed bench for the single-clock show-ahead FIFO (DEPTH=8,
// protected mode): reset, latency, fill/drain, wrap, errors, flush.
module tb_kanagawa_hal_sync_showahead_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       wrreq = 1'b0;
   logic       rdreq = 1'b0;
   logic [7:0] data = 8'h00;
   logic       full, almost_full, empty, almost_empty;
   logic       overflow, underflow;
   logic [7:0] q;
   logic [3:0] usedw;

   int errors = 0;
   int checks = 0;

   kanagawa_hal_sync_showahead_fifo #(
      .DEPTH(8), .LOG_DEPTH(3), .WIDTH(8), .USEDW_WIDTH(4),
      .ALMOSTFULL_ENTRIES(4), .ALMOSTEMPTY_ENTRIES(1),
      .USE_LUTRAM(0), .OVER_UNDER_FLOW_PROTECTION(1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wrreq(wrreq), .data(data), .full(full),
      .almost_full(almost_full), .rdreq(rdreq), .empty(empty),
      .almost_empty(almost_empty), .q(q), .usedw(usedw),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
      checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL rst_usedw got=%0d exp=0", usedw); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", overflow, underflow); end
      rst = 1'b0;
      checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL rst_af_hold got=%b exp=1", almost_full); end
      tick();
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af_release got=%b exp=0", almost_full); end
   endtask

   task automatic test_single();
      wrreq = 1'b1; data = 8'hA5;
      tick();
      wrreq = 1'b0;
      checks++; if (usedw !== 4'd1) begin errors++; $display("FAIL single_usedw got=%0d exp=1", usedw); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_n got=%b exp=1", empty); end
      tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_n1 got=%b exp=1", empty); end
      tick();
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_n2 got=%b exp=0", empty); end
      checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q got=%h exp=a5", q); end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
      checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL single_pop_usedw got=%0d exp=0", usedw); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         wrreq = 1'b1; data = 8'(i);
         tick();
         checks++; if (usedw !== 4'(i + 1)) begin errors++; $display("FAIL fill_usedw[%0d] got=%0d exp=%0d", i, usedw, i + 1); end
         checks++; if (almost_full !== (i + 1 >= 4)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 4)); end
         checks++; if (full !== (i + 1 == 8)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i + 1 == 8)); end
         checks++; if (almost_empty !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1 <= 1)); end
      end
      wrreq = 1'b0;
      rdreq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (empty !== 1'b0 || q !== 8'(i)) begin errors++; $display("FAIL drain_q[%0d] got=%h empty=%b exp=%h empty=0", i, q, empty, 8'(i)); end
         tick();
         checks++; if (usedw !== 4'(7 - i)) begin errors++; $display("FAIL drain_usedw[%0d] got=%0d exp=%0d", i, usedw, 7 - i); end
      end
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
      checks++; if (almost_full !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL drain_af got=%b%b exp=00", almost_full, full); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         wrreq = 1'b1; data = 8'(100 + i);
         tick();
      end
      wrreq = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 20; i++) begin
         wrreq = 1'b1; rdreq = 1'b1; data = 8'(103 + i);
         checks++; if (empty !== 1'b0 || q !== 8'(100 + i)) begin errors++; $display("FAIL b2b_q[%0d] got=%0d empty=%b exp=%0d", i, q, empty, 100 + i); end
         tick();
         checks++; if (usedw !== 4'd3) begin errors++; $display("FAIL b2b_usedw[%0d] got=%0d exp=3", i, usedw); end
      end
      wrreq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (empty !== 1'b0 || q !== 8'(120 + i)) begin errors++; $display("FAIL b2b_tail[%0d] got=%0d empty=%b exp=%0d", i, q, empty, 120 + i); end
         tick();
      end
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1 || usedw !== 4'd0) begin errors++; $display("FAIL b2b_end got empty=%b usedw=%0d exp empty=1 usedw=0", empty, usedw); end
   endtask

   task automatic test_protection();
      for (int i = 0; i < 8; i++) begin
         wrreq = 1'b1; data = 8'(16 + i);
         tick();
      end
      data = 8'hEE;
      tick();
      wrreq = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      checks++; if (usedw !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ovf_usedw got=%0d full=%b exp=8 full=1", usedw, full); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_no_udf got=%b exp=0", underflow); end
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      rdreq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (empty !== 1'b0 || q !== 8'(16 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h empty=%b exp=%h", i, q, empty, 8'(16 + i)); end
         tick();
      end
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_drained got empty=%b udf=%b exp 1 0", empty, underflow); end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", underflow); end
      checks++; if (usedw !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL udf_usedw got=%0d empty=%b exp=0 empty=1", usedw, empty); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL flags_flush got=%b%b exp=11", overflow, underflow); end
      rst = 1'b1;
      #1;
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flags_rst got=%b%b exp=00", overflow, underflow); end
      tick();
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         wrreq = 1'b1; data = 8'(80 + i);
         tick();
      end
      wrreq = 1'b0;
      tick();
      checks++; if (usedw !== 4'd5 || almost_full !== 1'b1) begin errors++; $display("FAIL flush_pre got usedw=%0d af=%b exp 5 1", usedw, almost_full); end
      flush = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'hFF;
      tick();
      flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
      checks++; if (usedw !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_state got usedw=%0d empty=%b exp 0 1", usedw, empty); end
      checks++; if (almost_full !== 1'b0 || full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL flush_status got af=%b f=%b ae=%b exp 0 0 1", almost_full, full, almost_empty); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flush_flags got=%b%b exp=00", overflow, underflow); end
      wrreq = 1'b1; data = 8'h3C;
      tick();
      wrreq = 1'b0;
      checks++; if (usedw !== 4'd1) begin errors++; $display("FAIL flush_wr_usedw got=%0d exp=1", usedw); end
      repeat (2) tick();
      checks++; if (empty !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL flush_wr_q got=%h empty=%b exp=3c empty=0", q, empty); end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1 || usedw !== 4'd0) begin errors++; $display("FAIL flush_end got empty=%b usedw=%0d exp 1 0", empty, usedw); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_protection();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
